// File: rtl/draw_pkg.sv
// Shared definitions for the draw-board sequencer: FSM state encoding,
// datapath code constants and geometry constants.
// Optional feature macro: BOARD_BG_CLEAR_EN (adds the background-fill state).
package draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BG,
    S_FETCH,
    S_CELL,
    S_ADV,
    S_TURN,
    S_DONE
  } draw_state_t;

  localparam int N_CELLS    = 64;
  localparam int CELL_PIX   = 256;
  localparam int BG_PIX     = 32768;
  localparam int CELL_PITCH = 17;
  localparam int TILE_PX    = 16;

  localparam logic [4:0] DV_BOARD = 5'b11000;
  localparam logic [4:0] DV_TURN  = 5'b11100;
  localparam logic [4:0] DV_EMPTY = 5'b00000;
  localparam logic [4:0] DV_BLOCK = 5'b11111;

  // The pixel counter only needs the long range when the background fill exists.
`ifdef BOARD_BG_CLEAR_EN
  localparam int PIX_W = 15;
`else
  localparam int PIX_W = 8;
`endif

  // Build the 6-bit datapath code {owner, code}.
  function automatic logic [5:0] dv_code(input logic owner, input logic [4:0] code);
    return {owner, code};
  endfunction

endpackage

// File: rtl/draw_pix_counter.sv
// Up-counter with a loadable terminal count. Wraps to 0 after the cycle in
// which it holds the terminal value; the wrap flag marks that final cycle.
module draw_pix_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             wrap
);

  logic [WIDTH-1:0] count;

  assign wrap = en && (count == terminal);

  // Count while enabled, return to zero on the terminal cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/draw_board_control.sv
// Draw-board sequencer: walks all 64 cells, feeding each cell's RAM code to
// the pixel datapath for one 16x16 tile, pulsing update_x_y between cells,
// and closing each frame with the turn-indicator tile.
// Optional feature macro: BOARD_BG_CLEAR_EN (white background fill first).
module draw_board_control
  import draw_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic [5:0] board_addr,
  input  logic [5:0] board_rdata,
  output logic       write,
  output logic       update_x_y,
  output logic [5:0] draw_value,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAT_LAST  = 4'(RAM_LAT);
  localparam logic [5:0] LAST_CELL = 6'(N_CELLS - 1);

  draw_state_t      state;
  logic             pending;
  logic [5:0]       cell_cnt;
  logic [3:0]       lat_cnt;
  logic             pix_en;
  logic [PIX_W-1:0] pix_term;
  logic             pix_wrap;

  // The cell counter doubles as the RAM address, so the address is registered.
  assign board_addr = cell_cnt;

`ifdef BOARD_BG_CLEAR_EN
  assign pix_en   = (state == S_BG) || (state == S_CELL) || (state == S_TURN);
  assign pix_term = (state == S_BG) ? PIX_W'(BG_PIX - 1) : PIX_W'(CELL_PIX - 1);
`else
  assign pix_en   = (state == S_CELL) || (state == S_TURN);
  assign pix_term = PIX_W'(CELL_PIX - 1);
`endif

  draw_pix_counter #(
    .WIDTH(PIX_W)
  ) u_pix_counter (
    .clk      (clk),
    .resetn   (resetn),
    .en       (pix_en),
    .terminal (pix_term),
    .wrap     (pix_wrap)
  );

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      write      <= 1'b0;
      update_x_y <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      draw_value <= '0;
      cell_cnt   <= '0;
      lat_cnt    <= '0;
    end else begin
      update_x_y <= 1'b0;
      done       <= 1'b0;
      // Any number of starts during a frame collapse into one extra frame.
      if (start && (state != S_IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start || pending) begin
            pending  <= 1'b0;
            busy     <= 1'b1;
            cell_cnt <= '0;
            lat_cnt  <= '0;
`ifdef BOARD_BG_CLEAR_EN
            write      <= 1'b1;
            draw_value <= dv_code(1'b0, DV_BOARD);
            state      <= S_BG;
`else
            state      <= S_FETCH;
`endif
          end
        end
`ifdef BOARD_BG_CLEAR_EN
        S_BG: begin
          if (pix_wrap) begin
            write <= 1'b0;
            state <= S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          // Address was presented on entry; capture once the RAM data is valid.
          if (lat_cnt == LAT_LAST) begin
            lat_cnt    <= '0;
            draw_value <= board_rdata;
            write      <= 1'b1;
            state      <= S_CELL;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_CELL: begin
          if (pix_wrap) begin
            write      <= 1'b0;
            update_x_y <= 1'b1;
            state      <= S_ADV;
          end
        end
        S_ADV: begin
          cell_cnt <= cell_cnt + 1'b1;
          if (cell_cnt == LAST_CELL) begin
            write      <= 1'b1;
            draw_value <= dv_code(1'b0, DV_TURN);
            state      <= S_TURN;
          end else begin
            state <= S_FETCH;
          end
        end
        S_TURN: begin
          if (pix_wrap) begin
            write <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
